// File: rtl/weight_preload_pbuf.sv
`default_nettype none
// ============================================================================
// weight_preload_pbuf: K x K weight preload buffer. Define WEIGHT_PRELOAD_DBUF_EN
// for a separate active bank; otherwise weights_out shows the shadow array.
// Revision: 1.0
// ============================================================================
module weight_preload_pbuf #(
    parameter int K  = 5,
    parameter int WW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [K*WW-1:0]     wt_in,
    input  logic                wt_valid,
    output logic                wt_ready,
    output logic                load_done,
    input  logic                swap,
    output logic [K*K*WW-1:0]   weights_out,
    output logic                active_valid
);
    localparam int c_cw = $clog2(K + 1);
    localparam int c_nb = K * K * WW;
    localparam logic [c_cw-1:0] c_last = c_cw'(K - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_cw-1:0]   r_col_cnt;
    logic [c_cw-1:0]   w_col_cnt_nxt;
    logic [c_nb-1:0]   r_sh;
    logic [c_nb-1:0]   w_sh_shift;
    logic              r_load_done;
    logic              r_active_valid;
    logic              w_accept;
    logic              w_last;
    logic              w_commit;
    logic              w_restart;
    logic              w_av_clr;

    // swap wins over start in FULL; a beat arriving with start is dropped
    always_comb begin
        w_commit      = (r_state == ST_FULL) && swap;
        w_restart     = start && !w_commit;
        w_accept      = (r_state == ST_LOAD) && wt_valid && !start;
        w_last        = w_accept && (r_col_cnt == c_last);
        w_state_nxt   = r_state;
        w_col_cnt_nxt = r_col_cnt;
        if (w_restart) begin
            w_state_nxt   = ST_LOAD;
            w_col_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_LOAD: begin
                    if (w_accept) begin
                        w_col_cnt_nxt = r_col_cnt + c_one;
                        if (w_last) begin
                            w_state_nxt = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (w_commit) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // New column enters at c=0; older columns move toward c=K-1
    for (genvar r = 0; r < K; r++) begin : g_row
        assign w_sh_shift[(r*K)*WW +: WW] = wt_in[r*WW +: WW];
        for (genvar c = 1; c < K; c++) begin : g_col
            assign w_sh_shift[((r*K)+c)*WW +: WW] = r_sh[((r*K)+c-1)*WW +: WW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_col_cnt      <= '0;
            r_sh           <= '0;
            r_load_done    <= 1'b0;
            r_active_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col_cnt   <= w_col_cnt_nxt;
            r_load_done <= w_last;
            if (w_accept) begin
                r_sh <= w_sh_shift;
            end
            if (w_commit) begin
                r_active_valid <= 1'b1;
            end else if (w_av_clr) begin
                r_active_valid <= 1'b0;
            end
        end
    end

`ifdef WEIGHT_PRELOAD_DBUF_EN
    logic [c_nb-1:0] r_ac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ac <= '0;
        end else if (w_commit) begin
            r_ac <= r_sh;
        end
    end

    assign w_av_clr    = 1'b0;
    assign weights_out = r_ac;
`else
    // Single bank: a new load invalidates the kernel the PE array sees
    assign w_av_clr    = w_restart;
    assign weights_out = r_sh;
`endif

    assign wt_ready     = (r_state == ST_LOAD);
    assign load_done    = r_load_done;
    assign active_valid = r_active_valid;

endmodule
`default_nettype wire

// File: tb/tb_weight_preload_pbuf.sv
`default_nettype none
// Bench for weight_preload_pbuf at K=5, WW=8: directed steps with a queue of
// expected committed kernels popped at each swap.
module tb_weight_preload_pbuf;
    localparam int K  = 5;
    localparam int WW = 8;
    localparam int CB = K * WW;
    localparam int NB = K * K * WW;
`ifdef WEIGHT_PRELOAD_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          wt_valid;
    logic          swap;
    logic [CB-1:0] wt_in;
    logic          wt_ready;
    logic          load_done;
    logic          active_valid;
    logic [NB-1:0] weights_out;

    int            n_cmp = 0;
    int            n_err = 0;
    int            acc_cnt = 0;
    int            done_cnt = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] exp_ac;
    logic [NB-1:0] exp_sh;
    logic [NB-1:0] kern_a;
    logic [CB-1:0] cols[K];

    always #5 clk = ~clk;

    weight_preload_pbuf #(.K(K), .WW(WW)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .wt_in        (wt_in),
        .wt_valid     (wt_valid),
        .wt_ready     (wt_ready),
        .load_done    (load_done),
        .swap         (swap),
        .weights_out  (weights_out),
        .active_valid (active_valid)
    );

    always @(posedge clk) begin
        if (rst_n && wt_valid && wt_ready && !start) acc_cnt++;
        if (rst_n && load_done) done_cnt++;
    end

    function automatic logic [CB-1:0] bcast(input logic [WW-1:0] v);
        logic [CB-1:0] b;
        for (int r = 0; r < K; r++) b[r*WW +: WW] = v;
        return b;
    endfunction

    // First column loaded lands in c=K-1, last in c=0
    function automatic logic [NB-1:0] kern();
        logic [NB-1:0] k;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                k[((r*K)+c)*WW +: WW] = cols[K-1-c][r*WW +: WW];
        return k;
    endfunction

    function automatic logic [NB-1:0] view(input logic [NB-1:0] sh);
        return DBUF ? exp_ac : sh;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_cols();
        for (int i = 0; i < K; i++)
            for (int r = 0; r < K; r++)
                cols[i][r*WW +: WW] = 8'($urandom);
    endtask

    task automatic beats();
        for (int i = 0; i < K; i++) begin
            wt_valid = 1'b1;
            wt_in    = cols[i];
            tick();
        end
        wt_valid = 1'b0;
    endtask

    task automatic commit(input string tag);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=empty_queue expected=kernel", tag);
        end else begin
            exp_ac = exp_q.pop_front();
            check(tag, weights_out, exp_ac);
            check({tag, "_av"}, active_valid, 1'b1);
        end
    endtask

    initial begin
        int a0;
        int d0;
        int n;
        int done_at;

        rst_n = 1'b0; start = 1'b0; wt_valid = 1'b0; swap = 1'b0; wt_in = '0;
        exp_ac = '0; exp_sh = '0;
        repeat (3) tick();
        check("rst_ready", wt_ready, 1'b0);
        check("rst_done", load_done, 1'b0);
        check("rst_av", active_valid, 1'b0);
        check("rst_wout", weights_out, '0);
        rst_n = 1'b1;
        tick();

        // Basic load: column i carries a 1 only in row i
        for (int i = 0; i < K; i++) begin
            cols[i] = '0;
            cols[i][i*WW +: WW] = 8'h01;
        end
        exp_q.push_back(kern());
        exp_sh = kern();
        a0 = acc_cnt;
        start = 1'b1; tick(); start = 1'b0;
        check("t1_ready_rise", wt_ready, 1'b1);
        beats();
        check("t1_load_done", load_done, 1'b1);
        check("t1_ready_fall", wt_ready, 1'b0);
        wt_valid = 1'b1; wt_in = bcast(8'hEE);
        tick();
        check("t1_full_ready", wt_ready, 1'b0);
        check("t1_done_pulse", load_done, 1'b0);
        check("t1_full_view", weights_out, view(exp_sh));
        tick();
        wt_valid = 1'b0;
        check("t1_accepts", acc_cnt - a0, 5);
        commit("t1_commit");
        check("t1_r0c4", weights_out[(0*K+4)*WW +: WW], 8'h01);
        check("t1_r4c0", weights_out[(4*K+0)*WW +: WW], 8'h01);

        // Handshake stall: valid toggles 1,0,1,... over columns 0x01..0x05
        for (int i = 0; i < K; i++) cols[i] = bcast(8'(i + 1));
        exp_q.push_back(kern());
        a0 = acc_cnt;
        done_at = 0;
        start = 1'b1; tick(); start = 1'b0;
        n = 1;
        for (int j = 0; j < 9; j++) begin
            wt_valid = (j % 2 == 0);
            wt_in    = cols[j/2];
            tick();
            n++;
            if (load_done && done_at == 0) done_at = n;
        end
        wt_valid = 1'b1; wt_in = bcast(8'hFF);
        repeat (2) tick();
        wt_valid = 1'b0;
        check("t2_done_at", done_at, 10);
        check("t2_accepts", acc_cnt - a0, 5);
        commit("t2_commit");
        check("t2_r2c0", weights_out[(2*K+0)*WW +: WW], 8'h05);
        check("t2_r2c4", weights_out[(2*K+4)*WW +: WW], 8'h01);

        // Double buffering, with a swap pulse during LOAD that must be ignored
        kern_a = exp_ac;
        rand_cols();
        exp_q.push_back(kern());
        exp_sh = kern();
        start = 1'b1; tick(); start = 1'b0;
        check("t3_av_after_start", active_valid, DBUF);
        for (int i = 0; i < K; i++) begin
            wt_valid = 1'b1;
            wt_in    = cols[i];
            swap     = (i == 2);
            tick();
            swap     = 1'b0;
`ifdef WEIGHT_PRELOAD_DBUF_EN
            check("t3_hold_a_load", weights_out, kern_a);
`endif
        end
        wt_valid = 1'b0;
        check("t3_load_done", load_done, 1'b1);
        check("t3_full_view", weights_out, DBUF ? kern_a : exp_sh);
        tick();
        commit("t3_commit");

        // Restart mid-load; the beat sent with the second start is dropped
        d0 = done_cnt;
        rand_cols();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wt_valid = 1'b1; wt_in = cols[i]; tick();
        end
        start = 1'b1; wt_valid = 1'b1; wt_in = bcast(8'h5A);
        tick();
        start = 1'b0;
        rand_cols();
        exp_q.push_back(kern());
        for (int i = 0; i < K; i++) begin
            wt_valid = 1'b1;
            wt_in    = cols[i];
            tick();
            if (i == K - 2) check("t4_no_early_done", load_done, 1'b0);
        end
        wt_valid = 1'b0;
        check("t4_load_done", load_done, 1'b1);
        tick();
        check("t4_done_once", done_cnt - d0, 1);
        commit("t4_commit");

        // FULL boundaries: held valid ignored; swap+start commits and idles
        rand_cols();
        exp_q.push_back(kern());
        exp_sh = kern();
        start = 1'b1; tick(); start = 1'b0;
        beats();
        check("t5_load_done", load_done, 1'b1);
        wt_valid = 1'b1; wt_in = bcast(8'hC3);
        tick();
        wt_valid = 1'b0;
        check("t5_full_ready", wt_ready, 1'b0);
        check("t5_full_view", weights_out, view(exp_sh));
        swap = 1'b1; start = 1'b1;
        tick();
        swap = 1'b0; start = 1'b0;
        exp_ac = exp_q.pop_front();
        check("t5_swapstart_wout", weights_out, exp_ac);
        check("t5_swapstart_av", active_valid, 1'b1);
        check("t5_swapstart_idle", wt_ready, 1'b0);
        tick();
        check("t5_no_restart", wt_ready, 1'b0);
        swap = 1'b1; tick(); swap = 1'b0;
        check("t5_idle_swap_av", active_valid, 1'b1);
        check("t5_idle_swap_wout", weights_out, exp_ac);

        // Asynchronous reset in the middle of LOAD
        start = 1'b1; tick(); start = 1'b0;
        wt_valid = 1'b1; wt_in = bcast(8'h11); tick();
        wt_in = bcast(8'h22); tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", wt_ready, 1'b0);
        check("t6_rst_done", load_done, 1'b0);
        check("t6_rst_av", active_valid, 1'b0);
        check("t6_rst_wout", weights_out, '0);
        tick();
        rst_n = 1'b1;
        a0 = acc_cnt;
        repeat (3) tick();
        wt_valid = 1'b0;
        check("t6_no_accept", acc_cnt - a0, 0);
        check("t6_ready_low", wt_ready, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
